debounced_led_counter: RTL and testbench

DEBOUNCED_LED_COUNTER -- requirements
Module: debounced_led_counter

---
 rtl/debounced_led_counter_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 75 +++++++
 rtl/debounced_led_counter.sv | 138 +++++++++++++
 tb/tb_debounced_led_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounced_led_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounced_led_counter_pkg
// Description : Shared definitions for the debounced LED counter: FSM state
//               enum and the bit positions its encoding is built around.
//               State bit 0 = direction (1 = up), bit 1 = paused, so a mode
//               press toggles bit 0 and a hold press toggles bit 1.
// Revision    : 1.0 - initial release
// ============================================================================
package debounced_led_counter_pkg;

    typedef enum logic [1:0] {
        RUN_DOWN   = 2'b00,
        RUN_UP     = 2'b01,
        PAUSE_DOWN = 2'b10,
        PAUSE_UP   = 2'b11
    } state_e;

    localparam int unsigned C_STATE_DIR_BIT   = 0;
    localparam int unsigned C_STATE_PAUSE_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Active-low button conditioner. 2-FF synchronizer followed by
//               a press debounce counter. pressed rises after DEBOUNCE_TIME
//               consecutive synchronized lows and drops on the first
//               synchronized high; press is a one-cycle pulse aligned with
//               the first cycle pressed is high.
// Ports       : clk     - system clock (rising edge)
//               rst     - synchronous active-high reset
//               btn_n   - raw active-low button, asynchronous to clk
//               pressed - debounced level
//               press   - one-cycle pulse on rising edge of pressed
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_TIME = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic pressed,
    output logic press
);

    localparam int              CW     = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [CW-1:0]   C_DONE = CW'(DEBOUNCE_TIME);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] w_cnt_inc;
    logic          pressed_q;
    logic          pressed_d;
    logic          press_q;

    assign w_cnt_inc = cnt_q + CW'(1);

    // The counter parks at C_DONE while the button stays low, so pressed
    // stays asserted without the counter wrapping.
    always_comb begin
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        if (sync2_q) begin
            cnt_d     = '0;
            pressed_d = 1'b0;
        end else if (cnt_q != C_DONE) begin
            cnt_d     = w_cnt_inc;
            pressed_d = (w_cnt_inc == C_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= pressed_d & ~pressed_q;
        end
    end

    assign pressed = pressed_q;
    assign press   = press_q;

endmodule

`default_nettype wire

// File: rtl/debounced_led_counter.sv
`default_nettype none
// ============================================================================
// Module      : debounced_led_counter
// Description : LED counter stepping once every WAIT_TIME cycles, controlled
//               by three debounced buttons: clear (level, loads PRESET),
//               mode (toggles direction) and hold (toggles run/pause).
//               Optional macro COUNTER_WRAP_EN: count wraps at the ends
//               instead of saturating.
// Ports       : clk        - system clock (rising edge)
//               rst        - synchronous active-high reset
//               btn_clr_n  - active-low clear button (async)
//               btn_mode_n - active-low direction toggle button (async)
//               btn_hold_n - active-low run/pause toggle button (async)
//               led        - current count (active-low LEDs)
//               tick       - one-cycle pulse on each count step
//               dir_up     - 1 = counting up
//               paused     - 1 = FSM in a paused state
// Revision    : 1.0 - initial release
// ============================================================================
module debounced_led_counter
    import debounced_led_counter_pkg::*;
#(
    parameter int               WIDTH         = 6,
    parameter int               WAIT_TIME     = 1350000,
    parameter int               DEBOUNCE_TIME = 500000,
    parameter logic [WIDTH-1:0] PRESET        = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_clr_n,
    input  logic             btn_mode_n,
    input  logic             btn_hold_n,
    output logic [WIDTH-1:0] led,
    output logic             tick,
    output logic             dir_up,
    output logic             paused
);

    localparam int            TW          = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
    localparam logic [TW-1:0] C_TICK_LAST = TW'(WAIT_TIME - 1);

    logic             w_clr_level;
    logic             w_clr_press;
    logic             w_mode_level;
    logic             w_mode_press;
    logic             w_hold_level;
    logic             w_hold_press;
    logic             w_unused;

    state_e           state_q;
    state_e           state_d;
    logic [TW-1:0]    tcnt_q;
    logic [TW-1:0]    tcnt_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             w_run;
    logic             w_up;
    logic             w_tick;

    btn_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_db_clr (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_clr_n),
        .pressed (w_clr_level),
        .press   (w_clr_press)
    );

    btn_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_db_mode (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_mode_n),
        .pressed (w_mode_level),
        .press   (w_mode_press)
    );

    btn_debounce #(.DEBOUNCE_TIME(DEBOUNCE_TIME)) u_db_hold (
        .clk     (clk),
        .rst     (rst),
        .btn_n   (btn_hold_n),
        .pressed (w_hold_level),
        .press   (w_hold_press)
    );

    // Clear acts on the level; mode/hold act on the edge pulse only.
    assign w_unused = w_clr_press ^ w_mode_level ^ w_hold_level;

    assign w_up   = state_q[C_STATE_DIR_BIT];
    assign w_run  = ~state_q[C_STATE_PAUSE_BIT];
    assign w_tick = w_run & ~w_clr_level & (tcnt_q == C_TICK_LAST);

    // The state encoding makes each press a single bit flip, so coincident
    // mode and hold presses compose naturally (e.g. RUN_DOWN -> PAUSE_UP).
    always_comb begin
        state_d = state_e'(state_q ^ {w_hold_press, w_mode_press});
    end

    always_comb begin
        tcnt_d  = tcnt_q;
        count_d = count_q;
        if (w_clr_level) begin
            tcnt_d  = '0;
            count_d = PRESET;
        end else if (w_run) begin
            tcnt_d = w_tick ? '0 : tcnt_q + TW'(1);
            if (w_tick) begin
`ifdef COUNTER_WRAP_EN
                count_d = w_up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
`else
                if (w_up) begin
                    if (count_q != '1) count_d = count_q + WIDTH'(1);
                end else begin
                    if (count_q != '0) count_d = count_q - WIDTH'(1);
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN_DOWN;
            tcnt_q  <= '0;
            count_q <= PRESET;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            count_q <= count_d;
        end
    end

    assign led    = count_q;
    assign tick   = w_tick;
    assign dir_up = state_q[C_STATE_DIR_BIT];
    assign paused = state_q[C_STATE_PAUSE_BIT];

endmodule

`default_nettype wire

// File: tb/tb_debounced_led_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounced_led_counter
// Description : Directed self-checking bench for debounced_led_counter with
//               WIDTH=4, WAIT_TIME=4, DEBOUNCE_TIME=3, PRESET=4'hF.
//               Inputs change and outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounced_led_counter;

`ifdef COUNTER_WRAP_EN
    localparam bit C_WRAP = 1'b1;
`else
    localparam bit C_WRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_clr_n;
    logic       btn_mode_n;
    logic       btn_hold_n;
    logic [3:0] led;
    logic       tick;
    logic       dir_up;
    logic       paused;

    int n_checks = 0;
    int n_fail   = 0;

    debounced_led_counter #(
        .WIDTH         (4),
        .WAIT_TIME     (4),
        .DEBOUNCE_TIME (3),
        .PRESET        (4'hF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_clr_n  (btn_clr_n),
        .btn_mode_n (btn_mode_n),
        .btn_hold_n (btn_hold_n),
        .led        (led),
        .tick       (tick),
        .dir_up     (dir_up),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bounded wait for a tick; an expired budget is itself a failed check.
    task automatic wait_tick(input int max_cyc);
        bit found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (tick) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("wait_tick", 32'(found), 32'd1);
    endtask

    function automatic logic [3:0] step_up(input logic [3:0] v);
        if (v == 4'hF) return C_WRAP ? 4'h0 : 4'hF;
        return v + 4'h1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] x;
        logic [3:0] exp_v;
        bit         found;

        rst = 1'b1; btn_clr_n = 1'b1; btn_mode_n = 1'b1; btn_hold_n = 1'b1;
        cyc(3);
        check_eq("rst_led",    32'(led),    32'hF);
        check_eq("rst_tick",   32'(tick),   32'd0);
        check_eq("rst_dir",    32'(dir_up), 32'd0);
        check_eq("rst_paused", 32'(paused), 32'd0);

        // Free-running count down: tick on every 4th cycle, step on the next.
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            check_eq("cnt_led",  32'(led),  32'(4'hF - 4'(k / 4)));
            check_eq("cnt_tick", 32'(tick), 32'((k % 4) == 3));
        end

        // Bounce: never three consecutive synchronized lows.
        for (int b = 0; b < 3; b++) begin
            btn_mode_n = 1'b0; cyc(2);
            btn_mode_n = 1'b1; cyc(1);
        end
        cyc(8);
        check_eq("bounce_dir", 32'(dir_up), 32'd0);

        // Clean press: pulse registered 5 edges in, state flips on the 6th.
        btn_mode_n = 1'b0; cyc(5); btn_mode_n = 1'b1;
        cyc(1);
        check_eq("mode_dir_up", 32'(dir_up), 32'd1);
        cyc(10);
        check_eq("mode_single", 32'(dir_up), 32'd1);
        wait_tick(8);
        x = led;
        cyc(1);
        check_eq("mode_inc", 32'(led), 32'(step_up(x)));

        // Back to down, then clear to PRESET.
        btn_mode_n = 1'b0; cyc(5); btn_mode_n = 1'b1;
        cyc(1);
        check_eq("mode_back_dn", 32'(dir_up), 32'd0);
        btn_clr_n = 1'b0; cyc(6);
        check_eq("clr_led",  32'(led),  32'hF);
        check_eq("clr_tick", 32'(tick), 32'd0);
        btn_clr_n = 1'b1;

        // Hold: pressed right after a tick; two more steps land before pause.
        wait_tick(12);
        x = led;
        btn_hold_n = 1'b0; cyc(5); btn_hold_n = 1'b1;
        cyc(1);
        check_eq("hold_paused", 32'(paused), 32'd1);
        check_eq("hold_led",    32'(led),    32'(x - 4'd2));
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            check_eq("hold_keep_led", 32'(led),  32'(x - 4'd2));
            check_eq("hold_no_tick",  32'(tick), 32'd0);
        end
        btn_hold_n = 1'b0; cyc(5); btn_hold_n = 1'b1;
        cyc(3);
        check_eq("resume_paused", 32'(paused), 32'd0);
        check_eq("resume_tick",   32'(tick),   32'd1);
        check_eq("resume_led0",   32'(led),    32'(x - 4'd2));
        cyc(1);
        check_eq("resume_led1",   32'(led),    32'(x - 4'd3));

        // Mode and hold together: RUN_DOWN -> PAUSE_UP, then clear in pause.
        btn_mode_n = 1'b0; btn_hold_n = 1'b0; cyc(5);
        btn_mode_n = 1'b1; btn_hold_n = 1'b1;
        cyc(1);
        check_eq("both_paused", 32'(paused), 32'd1);
        check_eq("both_dir",    32'(dir_up), 32'd1);
        btn_clr_n = 1'b0; cyc(6);
        check_eq("pclr_led",    32'(led),    32'hF);
        check_eq("pclr_paused", 32'(paused), 32'd1);
        check_eq("pclr_dir",    32'(dir_up), 32'd1);
        btn_clr_n = 1'b1; cyc(4);
        check_eq("pclr_keep",   32'(led),    32'hF);

        // Resume upward from F: wrap to 0 or saturate with tick still pulsing.
        btn_hold_n = 1'b0; cyc(5); btn_hold_n = 1'b1;
        cyc(4);
        check_eq("up_top_tick", 32'(tick), 32'd1);
        check_eq("up_top_led",  32'(led),  32'hF);
        cyc(1);
        exp_v = C_WRAP ? 4'h0 : 4'hF;
        check_eq("up_top_step", 32'(led),  32'(exp_v));
        cyc(3);
        check_eq("up_top_tick2", 32'(tick), 32'd1);
        check_eq("up_top_hold",  32'(led),  32'(exp_v));

        // Downward through 1 -> 0 -> (F or 0).
        btn_mode_n = 1'b0; cyc(5); btn_mode_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 120; i++) begin
            cyc(1);
            if (tick && led == 4'h1) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("wait_led1", 32'(found), 32'd1);
        cyc(1);
        check_eq("dn_led0",  32'(led),  32'h0);
        cyc(3);
        check_eq("dn_tick0", 32'(tick), 32'd1);
        check_eq("dn_hold0", 32'(led),  32'h0);
        cyc(1);
        check_eq("dn_bottom_step", 32'(led), C_WRAP ? 32'hF : 32'h0);

        // Reset mid-debounce and mid-period with clear held throughout.
        btn_clr_n = 1'b0; cyc(4);
        rst = 1'b1; cyc(1);
        check_eq("mrst_led",    32'(led),    32'hF);
        check_eq("mrst_tick",   32'(tick),   32'd0);
        check_eq("mrst_dir",    32'(dir_up), 32'd0);
        check_eq("mrst_paused", 32'(paused), 32'd0);
        rst = 1'b0;
        cyc(3);
        check_eq("mrst_tick3", 32'(tick), 32'd1);
        check_eq("mrst_led3",  32'(led),  32'hF);
        cyc(1);
        check_eq("mrst_led4",  32'(led),  32'hE);
        cyc(1);
        check_eq("mrst_led5",  32'(led),  32'hE);
        cyc(1);
        check_eq("mrst_clr6",  32'(led),  32'hF);
        check_eq("mrst_tick6", 32'(tick), 32'd0);
        btn_clr_n = 1'b1;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
